neuron_input_packer: RTL

- Serial-to-parallel front end for the fully connected neuron layer.
- Accepts one DATA_WIDTH fixed-point word per handshake from an upstream stream (conv/pool output).
- Assembles NEURON_INPUTS words into one vector and presents it on the neuron layer's parallel valid/ready input interface.
- Holds the vector stable until the layer accepts it. Upstream streaming continues with zero bubbles across vector boundaries.

---
 rtl/neuron_input_packer.sv | 113 +++++++++++
 1 files changed

// File: rtl/neuron_input_packer.sv
`default_nettype none
// ============================================================================
// neuron_input_packer : packs a word stream into NEURON_INPUTS-wide vectors
// Revision 1.0
// ============================================================================
module neuron_input_packer #(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned NEURON_INPUTS = 32
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 neuron_input_packer_clear,
   output logic                                 neuron_input_packer_ready_in,
   input  logic                                 neuron_input_packer_valid_in,
   input  logic [DATA_WIDTH-1:0]                neuron_input_packer_data_in,
   input  logic                                 neuron_input_packer_ready_out,
   output logic                                 neuron_input_packer_valid_out,
   output logic [DATA_WIDTH-1:0]                neuron_input_packer_data_out [0:NEURON_INPUTS-1],
   output logic [$clog2(NEURON_INPUTS+1)-1:0]   neuron_input_packer_count
);

   localparam int unsigned          c_cnt_w = $clog2(NEURON_INPUTS + 1);
   localparam logic [c_cnt_w-1:0]   c_last  = c_cnt_w'(NEURON_INPUTS - 1);
   localparam logic [c_cnt_w-1:0]   c_one   = c_cnt_w'(1);

   typedef enum logic [0:0] {
      ST_FILL = 1'b0,
      ST_FULL = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [c_cnt_w-1:0]   count_q, count_d;
   logic                 w_in_hs;
   logic                 w_out_hs;
   logic                 w_wr_en;
   logic [c_cnt_w-1:0]   w_wr_idx;

   // ready_in looks through to ready_out so a full vector drains and refills in one cycle
   assign neuron_input_packer_valid_out = (state_q == ST_FULL);
   assign neuron_input_packer_ready_in  = !neuron_input_packer_clear &&
                                          ((state_q == ST_FILL) || neuron_input_packer_ready_out);
   assign neuron_input_packer_count     = count_q;

   assign w_in_hs  = neuron_input_packer_valid_in  && neuron_input_packer_ready_in;
   assign w_out_hs = neuron_input_packer_valid_out && neuron_input_packer_ready_out;

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      w_wr_en  = 1'b0;
      w_wr_idx = count_q;
      if (neuron_input_packer_clear) begin
         state_d = ST_FILL;
         count_d = '0;
      end else begin
         case (state_q)
            ST_FILL: begin
               if (w_in_hs) begin
                  w_wr_en  = 1'b1;
                  w_wr_idx = count_q;
                  if (count_q == c_last) begin
                     count_d = '0;
                     state_d = ST_FULL;
                  end else begin
                     count_d = count_q + c_one;
                  end
               end
            end
            ST_FULL: begin
               if (w_out_hs) begin
                  state_d = ST_FILL;
                  if (w_in_hs) begin
                     // incoming word starts the next vector at slot 0
                     w_wr_en  = 1'b1;
                     w_wr_idx = '0;
                     if (NEURON_INPUTS == 1) begin
                        state_d = ST_FULL;
                     end else begin
                        count_d = c_one;
                     end
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_FILL;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   for (genvar gi = 0; gi < NEURON_INPUTS; gi++) begin : g_entry
      logic [DATA_WIDTH-1:0] entry_q;

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            entry_q <= '0;
         end else if (w_wr_en && (w_wr_idx == c_cnt_w'(gi))) begin
            entry_q <= neuron_input_packer_data_in;
         end
      end

      assign neuron_input_packer_data_out[gi] = entry_q;
   end

endmodule
`default_nettype wire
